crash_judge: RTL



---
 rtl/crash_judge_pkg.sv | 27 ++
 rtl/crash_judge_edge_detect.sv | 35 +++
 rtl/crash_judge.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/crash_judge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crash_judge_pkg
// Description : Shared widths and state encodings for the crash_judge block.
//               LIFE_WIDTH / BOMB_WIDTH size the life and bomb counters;
//               judge_state_t is the 2-bit FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package crash_judge_pkg;

  localparam int LIFE_WIDTH = 2;
  localparam int BOMB_WIDTH = 2;

  typedef enum logic [1:0] {
    JUDGE_IDLE   = 2'd0,
    JUDGE_PLAY   = 2'd1,
    JUDGE_INVULN = 2'd2,
    JUDGE_OVER   = 2'd3
  } judge_state_t;

  // Collisions are only reported while a game is actually in progress.
  function automatic logic is_live(judge_state_t s);
    return (s == JUDGE_PLAY) || (s == JUDGE_INVULN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crash_judge_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : crash_judge_edge_detect
// Description : 1-bit edge detector. The input is compared against a
//               registered copy of itself; rise_o / fall_o are one-cycle
//               pulses while the new level is present.
// Ports       : clk, rst (sync, active-high), d_i (level in),
//               rise_o (0->1 pulse), fall_o (1->0 pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module crash_judge_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= d_i;
    end
  end

  assign rise_o = d_i & ~r_prev;
  assign fall_o = ~d_i & r_prev;

endmodule
`default_nettype wire

// File: rtl/crash_judge.sv
`default_nettype none
// ============================================================================
// Module      : crash_judge
// Description : Collision arbiter in front of enemy_top. Produces the
//               combinational crash strobes, and owns lives, post-hit
//               invulnerability, bomb inventory/firing and game-over.
//               All game state advances on the vsync falling-edge frame tick.
// Ports       : clk_vga, rst (sync, active-high), en_i (game running),
//               v_sync_i (active-low vsync), me/bullet/enemy_alpha_i,
//               bomb_key_i (debounced level),
//               crash_enemy_bullet_o, crash_me_enemy_o, bomb_o,
//               life_o, bomb_cnt_o, invuln_o, game_over_o
// Revision    : 1.0 - initial release
// ============================================================================
module crash_judge
  import crash_judge_pkg::*;
#(
  parameter int LIFE_INIT     = 3,
  parameter int BOMB_INIT     = 2,
  parameter int INVULN_FRAMES = 60,
  parameter int BOMB_FRAMES   = 2
) (
  input  logic                  clk_vga,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  v_sync_i,
  input  logic                  me_alpha_i,
  input  logic                  bullet_alpha_i,
  input  logic                  enemy_alpha_i,
  input  logic                  bomb_key_i,
  output logic                  crash_enemy_bullet_o,
  output logic                  crash_me_enemy_o,
  output logic                  bomb_o,
  output logic [LIFE_WIDTH-1:0] life_o,
  output logic [BOMB_WIDTH-1:0] bomb_cnt_o,
  output logic                  invuln_o,
  output logic                  game_over_o
);

  localparam int c_inv_w = $clog2(INVULN_FRAMES + 1);
  localparam int c_bf_w  = $clog2(BOMB_FRAMES + 1);

  localparam logic [LIFE_WIDTH-1:0] c_life_init   = LIFE_WIDTH'(LIFE_INIT);
  localparam logic [BOMB_WIDTH-1:0] c_bomb_init   = BOMB_WIDTH'(BOMB_INIT);
  localparam logic [c_inv_w-1:0]    c_inv_frames  = c_inv_w'(INVULN_FRAMES);
  localparam logic [c_inv_w-1:0]    c_inv_one     = c_inv_w'(1);
  localparam logic [c_bf_w-1:0]     c_bomb_frames = c_bf_w'(BOMB_FRAMES);
  localparam logic [c_bf_w-1:0]     c_bf_one      = c_bf_w'(1);

  judge_state_t          r_state;
  logic [LIFE_WIDTH-1:0] r_life;
  logic [BOMB_WIDTH-1:0] r_bombs;
  logic [c_inv_w-1:0]    r_inv_cnt;
  logic [c_bf_w-1:0]     r_bomb_left;
  logic                  r_hit;
  logic                  r_pending;
  logic                  r_bomb;
  logic                  r_invuln;
  logic                  r_game_over;

  logic                  w_frame_tick;
  logic                  w_key_rise;
  logic                  w_vsync_rise_unused;
  logic                  w_key_fall_unused;
  logic                  w_unused_edges;
  logic [LIFE_WIDTH-1:0] w_life_dec;

  // vsync is active-low: the frame starts on its falling edge.
  crash_judge_edge_detect #(.RESET_VAL(1'b1)) u_vsync_edge (
    .clk    (clk_vga),
    .rst    (rst),
    .d_i    (v_sync_i),
    .rise_o (w_vsync_rise_unused),
    .fall_o (w_frame_tick)
  );

  crash_judge_edge_detect #(.RESET_VAL(1'b0)) u_key_edge (
    .clk    (clk_vga),
    .rst    (rst),
    .d_i    (bomb_key_i),
    .rise_o (w_key_rise),
    .fall_o (w_key_fall_unused)
  );

  assign w_unused_edges = w_vsync_rise_unused | w_key_fall_unused;

  // Zero-latency strobes so enemy_top gates them against the same pixel.
  assign crash_enemy_bullet_o = is_live(r_state) & bullet_alpha_i & enemy_alpha_i;
  assign crash_me_enemy_o     = is_live(r_state) & me_alpha_i & enemy_alpha_i;

  assign w_life_dec = (r_life == '0) ? '0 : r_life - 1'b1;

  always_ff @(posedge clk_vga) begin
    // Dropping en_i abandons the game outright, same as a reset.
    if (rst || !en_i) begin
      r_state     <= JUDGE_IDLE;
      r_life      <= c_life_init;
      r_bombs     <= c_bomb_init;
      r_inv_cnt   <= '0;
      r_bomb_left <= '0;
      r_hit       <= 1'b0;
      r_pending   <= 1'b0;
      r_bomb      <= 1'b0;
      r_invuln    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        JUDGE_IDLE: begin
          r_state     <= JUDGE_PLAY;
          r_life      <= c_life_init;
          r_bombs     <= c_bomb_init;
          r_inv_cnt   <= '0;
          r_bomb_left <= '0;
          r_hit       <= 1'b0;
          r_pending   <= 1'b0;
          r_bomb      <= 1'b0;
          r_invuln    <= 1'b0;
          r_game_over <= 1'b0;
        end

        JUDGE_PLAY, JUDGE_INVULN: begin
          // Bomb release on the tick after the press, then a fixed
          // number of frame ticks high.
          if (w_frame_tick) begin
            if (r_pending) begin
              r_pending   <= 1'b0;
              r_bomb      <= 1'b1;
              r_bomb_left <= c_bomb_frames;
            end else if (r_bomb) begin
              if (r_bomb_left <= c_bf_one) begin
                r_bomb <= 1'b0;
              end
              r_bomb_left <= r_bomb_left - 1'b1;
            end
          end

          if (w_key_rise && (r_bombs != '0) && !r_pending && !r_bomb) begin
            r_pending <= 1'b1;
            r_bombs   <= r_bombs - 1'b1;
          end

          if (r_state == JUDGE_PLAY) begin
            if (w_frame_tick && r_hit) begin
              r_hit  <= 1'b0;
              r_life <= w_life_dec;
              if (w_life_dec == '0) begin
                // Last life gone: cancel any bomb, overriding the
                // release above.
                r_state     <= JUDGE_OVER;
                r_game_over <= 1'b1;
                r_bomb      <= 1'b0;
                r_pending   <= 1'b0;
                r_bomb_left <= '0;
              end else begin
                r_state   <= JUDGE_INVULN;
                r_invuln  <= 1'b1;
                r_inv_cnt <= c_inv_frames;
              end
            end else if (crash_me_enemy_o) begin
              r_hit <= 1'b1;
            end
          end else begin
            r_hit <= 1'b0;
            if (w_frame_tick) begin
              if (r_inv_cnt <= c_inv_one) begin
                r_inv_cnt <= '0;
                r_invuln  <= 1'b0;
                r_state   <= JUDGE_PLAY;
              end else begin
                r_inv_cnt <= r_inv_cnt - 1'b1;
              end
            end
          end
        end

        JUDGE_OVER: begin
          r_game_over <= 1'b1;
        end

        default: begin
          r_state <= JUDGE_IDLE;
        end
      endcase
    end
  end

  assign bomb_o      = r_bomb;
  assign life_o      = r_life;
  assign bomb_cnt_o  = r_bombs;
  assign invuln_o    = r_invuln;
  assign game_over_o = r_game_over;

endmodule
`default_nettype wire
